// File: rtl/writeback_stage_pkg.sv
// Shared widths and the WB control bundle used by the EX/MEM and MEM/WB pipeline registers.
package writeback_stage_pkg;

  localparam int WB_DATA_WIDTH    = 16;
  localparam int WB_ADDRESS_WIDTH = 3;
  localparam int WB_COUNT_WIDTH   = 16;

  // Field order is fixed: {reg_write, mem_to_reg}.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  function automatic wb_ctrl_t pack_wb_ctrl(input logic reg_write, input logic mem_to_reg);
    wb_ctrl_t c;
    c.reg_write  = reg_write;
    c.mem_to_reg = mem_to_reg;
    return c;
  endfunction

endpackage

// File: rtl/writeback_stage_bypass_mux.sv
// Forwards the in-flight register file write to one decode read port.
module writeback_stage_bypass_mux
  import writeback_stage_pkg::*;
#(
  parameter int data_width    = WB_DATA_WIDTH,
  parameter int address_width = WB_ADDRESS_WIDTH
) (
  input  logic                     write_enable,
  input  logic [address_width-1:0] write_address,
  input  logic [data_width-1:0]    write_data,
  input  logic [address_width-1:0] read_address,
  input  logic [data_width-1:0]    read_data,
  output logic [data_width-1:0]    bypass_data
);

  logic hit;

  assign hit         = write_enable && (write_address == read_address);
  assign bypass_data = hit ? write_data : read_data;

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, register file write port, decode bypass and retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int data_width    = WB_DATA_WIDTH,
  parameter int address_width = WB_ADDRESS_WIDTH,
  parameter int count_width   = WB_COUNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_reg_write,
  input  logic                     in_mem_to_reg,
  input  logic [data_width-1:0]    in_alu_result,
  input  logic [data_width-1:0]    in_mem_data,
  input  logic [address_width-1:0] in_dest,
  input  logic [address_width-1:0] read_address1,
  input  logic [address_width-1:0] read_address2,
  input  logic [data_width-1:0]    read_data1,
  input  logic [data_width-1:0]    read_data2,
  output logic                     write_enable,
  output logic [data_width-1:0]    write_data,
  output logic [address_width-1:0] write_address,
  output logic [data_width-1:0]    bypass_data1,
  output logic [data_width-1:0]    bypass_data2,
  output logic [count_width-1:0]   retired_count
);

  logic                     wb_valid_q,  wb_valid_d;
  wb_ctrl_t                 wb_ctrl_q,   wb_ctrl_d;
  logic [data_width-1:0]    wb_alu_q,    wb_alu_d;
  logic [data_width-1:0]    wb_mem_q,    wb_mem_d;
  logic [address_width-1:0] wb_dest_q,   wb_dest_d;
  logic [count_width-1:0]   retired_q,   retired_d;
  logic                     retire;

  // Flush only clears the valid bit; the payload is don't-care once invalid.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_ctrl_d  = wb_ctrl_q;
    wb_alu_d   = wb_alu_q;
    wb_mem_d   = wb_mem_q;
    wb_dest_d  = wb_dest_q;
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (!stall) begin
      wb_valid_d = in_valid;
      wb_ctrl_d  = pack_wb_ctrl(in_reg_write, in_mem_to_reg);
      wb_alu_d   = in_alu_result;
      wb_mem_d   = in_mem_data;
      wb_dest_d  = in_dest;
    end
  end

  assign retire = wb_valid_q && !stall && !flush;

  always_comb begin
    retired_d = retired_q;
    if (retire) retired_d = retired_q + count_width'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_ctrl_q  <= '0;
      wb_alu_q   <= '0;
      wb_mem_q   <= '0;
      wb_dest_q  <= '0;
      retired_q  <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_alu_q   <= wb_alu_d;
      wb_mem_q   <= wb_mem_d;
      wb_dest_q  <= wb_dest_d;
      retired_q  <= retired_d;
    end
  end

  // A stalled cycle is re-presented later, so suppressing the strobe avoids a double commit.
  assign write_enable  = wb_valid_q & wb_ctrl_q.reg_write & ~stall;
  assign write_data    = wb_ctrl_q.mem_to_reg ? wb_mem_q : wb_alu_q;
  assign write_address = wb_dest_q;
  assign retired_count = retired_q;

  writeback_stage_bypass_mux #(
    .data_width    (data_width),
    .address_width (address_width)
  ) u_bypass1 (
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address1),
    .read_data     (read_data1),
    .bypass_data   (bypass_data1)
  );

  writeback_stage_bypass_mux #(
    .data_width    (data_width),
    .address_width (address_width)
  ) u_bypass2 (
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address2),
    .read_data     (read_data2),
    .bypass_data   (bypass_data2)
  );

endmodule
